// File: rtl/brick_draw_pkg.sv
// Shared defaults, background colour and FSM state type for the rectangle rasteriser.
package brick_draw_pkg;

    localparam int DEF_COORD_W  = 10;
    localparam int DEF_SIZE_W   = 6;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;

    localparam logic [2:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } draw_state_t;

endpackage

// File: rtl/xy_scan_counter.sv
// Two-dimensional raster counter: cx sweeps 0..w-1 inside each row, cy advances per row.
module xy_scan_counter #(
    parameter int SIZE_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [SIZE_W-1:0] i_w,
    input  logic [SIZE_W-1:0] i_h,
    output logic [SIZE_W-1:0] o_cx,
    output logic [SIZE_W-1:0] o_cy,
    output logic              o_last
);

    logic [SIZE_W-1:0] r_cx;
    logic [SIZE_W-1:0] r_cy;
    logic              w_endRow;

    assign w_endRow = (r_cx == i_w - SIZE_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_clear) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_step) begin
            if (w_endRow) begin
                r_cx <= '0;
                r_cy <= r_cy + SIZE_W'(1);
            end else begin
                r_cx <= r_cx + SIZE_W'(1);
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = w_endRow && (r_cy == i_h - SIZE_W'(1));

endmodule

// File: rtl/rect_draw.sv
// Rectangle rasteriser emitting one pixel write per cycle with a start/busy/done handshake.
// Define RECT_DRAW_CLIP_EN to suppress writes that fall outside SCREEN_W x SCREEN_H.
module rect_draw
    import brick_draw_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int SIZE_W   = DEF_SIZE_W,
    parameter int COLOUR_W = DEF_COLOUR_W
`ifdef RECT_DRAW_CLIP_EN
    ,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [COORD_W-1:0]  x_in,
    input  logic [COORD_W-1:0]  y_in,
    input  logic [SIZE_W-1:0]   w_in,
    input  logic [SIZE_W-1:0]   h_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                erase,
    output logic                busy,
    output logic                done,
    output logic                wren,
    output logic [COORD_W-1:0]  x_out,
    output logic [COORD_W-1:0]  y_out,
    output logic [COLOUR_W-1:0] colour
);

    draw_state_t         r_state;
    draw_state_t         w_nextState;
    logic [COORD_W-1:0]  r_x;
    logic [COORD_W-1:0]  r_y;
    logic [SIZE_W-1:0]   r_w;
    logic [SIZE_W-1:0]   r_h;
    logic [COLOUR_W-1:0] r_colour;
    logic                w_accept;
    logic                w_step;
    logic                w_last;
    logic [SIZE_W-1:0]   w_cx;
    logic [SIZE_W-1:0]   w_cy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An empty rectangle skips DRAW entirely so no write strobe is ever raised for it.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_nextState = (w_in == '0 || h_in == '0) ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x      <= '0;
            r_y      <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_colour <= '0;
        end else if (w_accept) begin
            r_x      <= x_in;
            r_y      <= y_in;
            r_w      <= w_in;
            r_h      <= h_in;
            r_colour <= erase ? COLOUR_W'(BG_COLOUR) : colour_in;
        end
    end

    xy_scan_counter #(
        .SIZE_W (SIZE_W)
    ) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (w_accept),
        .i_step  (w_step),
        .i_w     (r_w),
        .i_h     (r_h),
        .o_cx    (w_cx),
        .o_cy    (w_cy),
        .o_last  (w_last)
    );

`ifdef RECT_DRAW_CLIP_EN
    // The extra sum bit makes coordinates that wrap past 2^COORD_W clip as off-screen.
    logic [COORD_W:0] w_sumX;
    logic [COORD_W:0] w_sumY;

    assign w_sumX = {1'b0, r_x} + (COORD_W+1)'(w_cx);
    assign w_sumY = {1'b0, r_y} + (COORD_W+1)'(w_cy);
    assign x_out  = w_sumX[COORD_W-1:0];
    assign y_out  = w_sumY[COORD_W-1:0];
    assign wren   = w_step && (w_sumX < (COORD_W+1)'(SCREEN_W))
                           && (w_sumY < (COORD_W+1)'(SCREEN_H));
`else
    assign x_out = r_x + COORD_W'(w_cx);
    assign y_out = r_y + COORD_W'(w_cy);
    assign wren  = w_step;
`endif

    assign colour = r_colour;

endmodule

// File: tb/tb_rect_draw.sv
// Bench for rect_draw: queue-based reference of expected per-cycle outputs plus literal pins.
// Honours RECT_DRAW_CLIP_EN the same way the design does.
module tb_rect_draw;

    localparam int COORD_W  = 10;
    localparam int SIZE_W   = 6;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    typedef struct {
        bit busy;
        bit done;
        bit wren;
        int x;
        int y;
        int col;
    } cycle_t;

    logic                clk = 1'b0;
    logic                resetn;
    logic                start;
    logic [COORD_W-1:0]  x_in;
    logic [COORD_W-1:0]  y_in;
    logic [SIZE_W-1:0]   w_in;
    logic [SIZE_W-1:0]   h_in;
    logic [COLOUR_W-1:0] colour_in;
    logic                erase;
    logic                busy;
    logic                done;
    logic                wren;
    logic [COORD_W-1:0]  x_out;
    logic [COORD_W-1:0]  y_out;
    logic [COLOUR_W-1:0] colour;

    int     compared = 0;
    int     failed   = 0;
    bit     checkEn  = 1'b0;
    cycle_t cur      = '{default: 0};
    cycle_t pending[$];
    int     litX[6]  = '{10, 11, 10, 11, 10, 11};
    int     litY[6]  = '{20, 20, 21, 21, 22, 22};

    rect_draw dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .w_in      (w_in),
        .h_in      (h_in),
        .colour_in (colour_in),
        .erase     (erase),
        .busy      (busy),
        .done      (done),
        .wren      (wren),
        .x_out     (x_out),
        .y_out     (y_out),
        .colour    (colour)
    );

    always #5 clk = ~clk;

    // Reference: an accepted request expands into its full list of expected cycles.
    always @(posedge clk) begin
        if (!resetn) begin
            pending.delete();
            cur = '{default: 0};
        end else begin
            if (!cur.busy && start) begin
                for (int cy = 0; cy < int'(h_in); cy++) begin
                    for (int cx = 0; cx < int'(w_in); cx++) begin
                        cycle_t c;
                        int     px;
                        int     py;
                        px     = int'(x_in) + cx;
                        py     = int'(y_in) + cy;
                        c.busy = 1'b1;
                        c.done = 1'b0;
`ifdef RECT_DRAW_CLIP_EN
                        c.wren = (px < SCREEN_W) && (py < SCREEN_H);
`else
                        c.wren = 1'b1;
`endif
                        c.x    = px % (1 << COORD_W);
                        c.y    = py % (1 << COORD_W);
                        c.col  = erase ? 0 : int'(colour_in);
                        pending.push_back(c);
                    end
                end
                pending.push_back('{busy: 1'b1, done: 1'b1, wren: 1'b0, x: 0, y: 0, col: 0});
            end
            if (pending.size() > 0) cur = pending.pop_front();
            else                    cur = '{default: 0};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 32'(busy), 32'(cur.busy));
            checkOutput("done", 32'(done), 32'(cur.done));
            checkOutput("wren", 32'(wren), 32'(cur.wren));
            if (cur.wren) begin
                checkOutput("xOut",   32'(x_out),  cur.x);
                checkOutput("yOut",   32'(y_out),  cur.y);
                checkOutput("colour", 32'(colour), cur.col);
            end
        end
    end

    task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                 input int col, input bit er);
        @(posedge clk);
        #2;
        x_in      = COORD_W'(x);
        y_in      = COORD_W'(y);
        w_in      = SIZE_W'(w);
        h_in      = SIZE_W'(h);
        colour_in = COLOUR_W'(col);
        erase     = er;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start     = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            compared++;
            failed++;
            $display("[TB] FAIL idleTimeout: busy=%0b after %0d cycles, expected 0", busy, n);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        w_in      = '0;
        h_in      = '0;
        colour_in = '0;
        erase     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn  = 1'b1;
        checkEn = 1'b1;

        @(negedge clk);
        checkOutput("rstBusy",   32'(busy),   0);
        checkOutput("rstWren",   32'(wren),   0);
        checkOutput("rstX",      32'(x_out),  0);
        checkOutput("rstY",      32'(y_out),  0);
        checkOutput("rstColour", 32'(colour), 0);

        $display("[TB] basic 2x3 draw");
        applyStimulus(10, 20, 2, 3, 5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("litWren",   32'(wren),   1);
            checkOutput("litX",      32'(x_out),  litX[i]);
            checkOutput("litY",      32'(y_out),  litY[i]);
            checkOutput("litColour", 32'(colour), 5);
        end
        @(negedge clk);
        checkOutput("litDone",     32'(done), 1);
        checkOutput("litDoneWren", 32'(wren), 0);
        waitIdle();

        $display("[TB] erase 2x3");
        applyStimulus(10, 20, 2, 3, 5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("eraseX",      32'(x_out),  litX[i]);
            checkOutput("eraseColour", 32'(colour), 0);
        end
        waitIdle();

        $display("[TB] empty rectangle");
        applyStimulus(30, 40, 0, 5, 2, 1'b0);
        @(negedge clk);
        checkOutput("emptyDone", 32'(done), 1);
        checkOutput("emptyBusy", 32'(busy), 1);
        checkOutput("emptyWren", 32'(wren), 0);
        @(negedge clk);
        checkOutput("emptyIdle", 32'(busy), 0);
        waitIdle();

        $display("[TB] start during draw");
        applyStimulus(100, 50, 3, 2, 3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        start     = 1'b1;
        x_in      = 10'd7;
        w_in      = 6'd9;
        colour_in = 3'd6;
        @(negedge clk);
        checkOutput("ignoreX",      32'(x_out),  102);
        checkOutput("ignoreColour", 32'(colour), 3);
        #1;
        start = 1'b0;
        waitIdle();

        $display("[TB] reset mid-draw");
        applyStimulus(5, 7, 4, 4, 1, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("rstMidWren", 32'(wren), 0);
        checkOutput("rstMidBusy", 32'(busy), 0);
        applyStimulus(5, 7, 4, 4, 1, 1'b0);
        @(negedge clk);
        checkOutput("restartX", 32'(x_out), 5);
        checkOutput("restartY", 32'(y_out), 7);
        waitIdle();

        $display("[TB] right-edge rectangle");
        applyStimulus(318, 0, 4, 1, 7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("edgeBusy", 32'(busy), 1);
`ifdef RECT_DRAW_CLIP_EN
            checkOutput("edgeWren", 32'(wren), (i < 2) ? 1 : 0);
`else
            checkOutput("edgeWren", 32'(wren), 1);
            checkOutput("edgeX",    32'(x_out), (318 + i) % 1024);
`endif
        end
        waitIdle();

        $display("[TB] back-to-back with start held");
        @(posedge clk);
        #2;
        x_in = 10'd1; y_in = 10'd2; w_in = 6'd1; h_in = 6'd1;
        colour_in = 3'd4; erase = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2bWren1", 32'(wren), 1);
        @(negedge clk);
        checkOutput("b2bDone",  32'(done), 1);
        @(negedge clk);
        checkOutput("b2bIdle",  32'(busy), 0);
        @(negedge clk);
        checkOutput("b2bWren2", 32'(wren), 1);
        #1;
        start = 1'b0;
        waitIdle();

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            resetn    = ($urandom_range(0, 149) != 0);
            start     = ($urandom_range(0, 3) == 0);
            x_in      = COORD_W'($urandom_range(0, 1023));
            y_in      = COORD_W'($urandom_range(0, 1023));
            w_in      = SIZE_W'($urandom_range(0, 7));
            h_in      = SIZE_W'($urandom_range(0, 5));
            colour_in = COLOUR_W'($urandom_range(0, 7));
            erase     = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #2;
        resetn = 1'b1;
        start  = 1'b0;
        waitIdle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
